// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types, arbitration-mode names and index helper for the frame arbiter
package axis_arb_pkg;

    typedef enum logic {IDLE, ACTIVE} arb_state_t;

    localparam string ARB_PRIORITY    = "PRIORITY";
    localparam string ARB_ROUND_ROBIN = "ROUND_ROBIN";

    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < 16; i++)
            if (oh[i]) onehot_to_idx = onehot_to_idx | 4'(i);
    endfunction

endpackage

// File: rtl/axis_arb_pick.sv
// axis_arb_pick: masked priority picker that falls back to the unmasked request vector
module axis_arb_pick
    import axis_arb_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int SEL_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] mask,
    input  logic             lsb_high,
    output logic [PORTS-1:0] pick,
    output logic [SEL_W-1:0] index
);

    logic [PORTS-1:0] masked;
    logic [PORTS-1:0] src;
    logic [3:0]       idx;

    assign masked = request & mask;
    assign src    = masked != '0 ? masked : request;

    // later iterations overwrite earlier ones, so the loop ends on the highest-priority bit
    always_comb begin
        pick = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!lsb_high && src[i]) pick = PORTS'(1) << i;
            if (lsb_high && src[PORTS-1-i]) pick = PORTS'(1) << (PORTS - 1 - i);
        end
    end

    assign idx   = onehot_to_idx(16'(pick));
    assign index = idx[SEL_W-1:0];

endmodule

// File: rtl/axis_frame_arb_ctrl.sv
// axis_frame_arb_ctrl: frame-aware arbiter driving a shared AXI-Stream mux, with stall watchdog
module axis_frame_arb_ctrl
    import axis_arb_pkg::*;
#(
    parameter  int    PORTS        = 4,
    parameter  string ARB_TYPE     = "ROUND_ROBIN",
    parameter  string LSB_PRIORITY = "HIGH",
    parameter  int    TIMEOUT      = 256,
    localparam int    SEL_W        = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic             out_tvalid,
    input  logic             out_tready,
    input  logic             out_tlast,
    output logic             enable,
    output logic [SEL_W-1:0] select,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic             timeout_err,
    output logic [15:0]      frame_cnt
);

    localparam bit RR       = ARB_TYPE == ARB_ROUND_ROBIN;
    localparam bit LSB_HIGH = LSB_PRIORITY == "HIGH";
    localparam int WD_W     = $clog2(TIMEOUT + 2);

    arb_state_t       state;
    logic [SEL_W-1:0] last_idx;
    logic [SEL_W-1:0] pick_idx;
    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] pick;
    logic [WD_W-1:0]  wd_cnt;
    logic             beat;
    logic             eof;
    logic             expire;

    assign beat        = out_tvalid & out_tready;
    assign eof         = beat & out_tlast;
    assign expire      = TIMEOUT != 0 && !beat && wd_cnt == WD_W'(TIMEOUT - 1);
    assign grant_valid = enable;

    // round-robin mask keeps only ports strictly past the last winner in search order
    always_comb begin
        mask = '0;
        for (int i = 0; i < PORTS; i++)
            mask[i] = RR && (LSB_HIGH ? i > int'(last_idx) : i < int'(last_idx));
    end

    axis_arb_pick #(.PORTS(PORTS)) u_pick (
        .request  (request),
        .mask     (mask),
        .lsb_high (LSB_HIGH),
        .pick     (pick),
        .index    (pick_idx)
    );

    always_ff @(posedge clk) begin
        timeout_err <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            enable    <= 1'b0;
            select    <= '0;
            grant     <= '0;
            frame_cnt <= '0;
            wd_cnt    <= '0;
            last_idx  <= LSB_HIGH ? SEL_W'(PORTS - 1) : '0;
        end else if (state == IDLE) begin
            if (request != '0) begin
                state    <= ACTIVE;
                enable   <= 1'b1;
                grant    <= pick;
                select   <= pick_idx;
                last_idx <= pick_idx;
                wd_cnt   <= '0;
            end
        end else if (eof || expire) begin
            state       <= IDLE;
            enable      <= 1'b0;
            grant       <= '0;
            select      <= '0;
            frame_cnt   <= frame_cnt + 16'(eof);
            timeout_err <= !eof;
        end else begin
            wd_cnt <= beat ? '0 : wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_frame_arb_ctrl.sv
// tb_axis_frame_arb_ctrl: vector table, directed corner sequences and random traffic against a reference model
module tb_axis_frame_arb_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] request = '0;
    logic       out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;

    logic en0, gv0, te0, en1, gv1, te1, en2, gv2, te2;
    logic [1:0]  sel0, sel1, sel2;
    logic [3:0]  g0, g1, g2;
    logic [15:0] fc0, fc1, fc2;

    always #5 clk = ~clk;

    axis_frame_arb_ctrl #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH"), .TIMEOUT(16)) u_rr (
        .clk(clk), .rst(rst), .request(request), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .enable(en0), .select(sel0), .grant(g0), .grant_valid(gv0),
        .timeout_err(te0), .frame_cnt(fc0));

    axis_frame_arb_ctrl #(.PORTS(4), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH"), .TIMEOUT(8)) u_pr (
        .clk(clk), .rst(rst), .request(request), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .enable(en1), .select(sel1), .grant(g1), .grant_valid(gv1),
        .timeout_err(te1), .frame_cnt(fc1));

    axis_frame_arb_ctrl #(.PORTS(4), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"), .TIMEOUT(0)) u_lo (
        .clk(clk), .rst(rst), .request(request), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .enable(en2), .select(sel2), .grant(g2), .grant_valid(gv2),
        .timeout_err(te2), .frame_cnt(fc2));

    bit is_rr  [N] = '{1'b1, 1'b0, 1'b1};
    bit lsb_hi [N] = '{1'b1, 1'b1, 1'b0};
    int to     [N] = '{16, 8, 0};

    bit m_busy [N];
    bit m_terr [N];
    int m_idx  [N];
    int m_last [N];
    int m_wd   [N];
    int m_fc   [N];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        v, r, l;
        logic [3:0]  g_rr, g_pr;
        logic [15:0] fc_rr;
    } vec_t;

    vec_t tbl [13];

    function automatic int winner(int k, logic [3:0] req);
        int p;
        for (int j = 1; j <= 4; j++) begin
            if (!is_rr[k]) p = lsb_hi[k] ? j - 1 : 4 - j;
            else p = lsb_hi[k] ? (m_last[k] + j) % 4 : (m_last[k] - j + 4) % 4;
            if (req[p]) return p;
        end
        return 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            m_terr[k] = 1'b0;
            if (rst) begin
                m_busy[k] = 1'b0;
                m_last[k] = lsb_hi[k] ? 3 : 0;
                m_wd[k] = 0;
                m_fc[k] = 0;
            end else if (!m_busy[k]) begin
                if (request != 4'b0) begin
                    m_idx[k] = winner(k, request);
                    m_last[k] = m_idx[k];
                    m_busy[k] = 1'b1;
                    m_wd[k] = 0;
                end
            end else if (out_tvalid && out_tready && out_tlast) begin
                m_busy[k] = 1'b0;
                m_fc[k] = (m_fc[k] + 1) % 65536;
            end else if (out_tvalid && out_tready) begin
                m_wd[k] = 0;
            end else begin
                m_wd[k]++;
                if (to[k] != 0 && m_wd[k] == to[k]) begin
                    m_busy[k] = 1'b0;
                    m_terr[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] act_of(int k);
        case (k)
            0: return {7'b0, en0, gv0, te0, sel0, g0, fc0};
            1: return {7'b0, en1, gv1, te1, sel1, g1, fc1};
            default: return {7'b0, en2, gv2, te2, sel2, g2, fc2};
        endcase
    endfunction

    function automatic logic [31:0] exp_of(int k);
        logic [1:0] s = m_busy[k] ? 2'(m_idx[k]) : 2'b0;
        logic [3:0] g = m_busy[k] ? 4'(1 << m_idx[k]) : 4'b0;
        return {7'b0, m_busy[k], m_busy[k], m_terr[k], s, g, 16'(m_fc[k])};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r_, input logic [3:0] req, input logic v, input logic rd, input logic l);
        rst = r_;
        request = req;
        out_tvalid = v;
        out_tready = rd;
        out_tlast = l;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("model_dut%0d", k), act_of(k), exp_of(k));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'hf, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd0};
        tbl[1]  = '{1'b1, 4'hf, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd0};
        tbl[2]  = '{1'b1, 4'hf, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd0};
        tbl[3]  = '{1'b0, 4'hf, 1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 16'd0};
        tbl[4]  = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 16'd1};
        tbl[5]  = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h2, 4'h1, 16'd1};
        tbl[6]  = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 16'd2};
        tbl[7]  = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h4, 4'h1, 16'd2};
        tbl[8]  = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 16'd3};
        tbl[9]  = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h8, 4'h1, 16'd3};
        tbl[10] = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 16'd4};
        tbl[11] = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 16'd4};
        tbl[12] = '{1'b0, 4'hf, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 16'd5};

        // reset and round-robin rotation over constant full request
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].v, tbl[i].r, tbl[i].l);
            chk($sformatf("tbl%0d_g_rr", i), 32'(g0), 32'(tbl[i].g_rr));
            chk($sformatf("tbl%0d_g_pr", i), 32'(g1), 32'(tbl[i].g_pr));
            chk($sformatf("tbl%0d_en_rr", i), 32'(en0), 32'(tbl[i].g_rr != 4'h0));
            chk($sformatf("tbl%0d_fc_rr", i), 32'(fc0), 32'(tbl[i].fc_rr));
        end

        // priority arbitration, two 3-beat frames
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
        chk("pri_grant", 32'(g1), 32'h2);
        chk("pri_select", 32'(sel1), 32'h1);
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                cycle(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
                chk("pri_regrant", 32'(g1), 32'h2);
            end
            for (int b = 0; b < 3; b++) begin
                cycle(1'b0, 4'b1010, 1'b1, 1'b1, b == 2);
                chk($sformatf("pri_f%0d_b%0d", f, b), 32'(g1), b == 2 ? 32'h0 : 32'h2);
            end
        end
        chk("pri_frames", 32'(fc1), 32'd2);

        // request drop and long tready stall do not release the grant
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("stall_grant", 32'(g0), 32'h4);
        cycle(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
            chk($sformatf("stall_hold%0d", i), 32'(g0), 32'h4);
        end
        cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        chk("stall_release", 32'(g0), 32'h0);

        // watchdog expiry, then a tlast beat landing exactly on the expiry cycle
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int rep = 0; rep < 2; rep++) begin
            cycle(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
            chk($sformatf("wd%0d_grant", rep), 32'(g1), 32'h8);
            for (int i = 0; i < 7; i++) begin
                cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
                chk($sformatf("wd%0d_hold%0d", rep, i), 32'({te1, g1}), 32'h8);
            end
            cycle(1'b0, 4'b0000, rep == 1, rep == 1, rep == 1);
            chk($sformatf("wd%0d_release", rep), 32'(g1), 32'h0);
            chk($sformatf("wd%0d_terr", rep), 32'(te1), 32'(rep == 0));
            chk($sformatf("wd%0d_fc", rep), 32'(fc1), 32'(rep));
            cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
            chk($sformatf("wd%0d_terr_pulse", rep), 32'(te1), 32'h0);
        end

        // reset in the middle of a frame on port 1
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("mid_grant", 32'(g0), 32'h2);
        chk("mid_fc_before", 32'(fc0), 32'd1);
        cycle(1'b0, 4'b0010, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 4'b0010, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_grant", 32'({en0, g0}), 32'h0);
        chk("mid_rst_fc", 32'(fc0), 32'd0);
        cycle(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("mid_restart", 32'(g0), 32'h1);

        // random traffic, alternating fluent and stall-heavy blocks
        for (int blk = 0; blk < 6; blk++)
            for (int i = 0; i < 500; i++)
                cycle($urandom_range(0, 199) == 0, 4'($urandom),
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) < ((blk % 2) != 0 ? 1 : 7),
                      $urandom_range(0, 2) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
